// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - frame state encoding (IDLE/START/DATA/PARITY/STOP naming)
//   - stop-bit mode constants carried on the stop_bits setting
//   - default fabric clock frequency
//   - parity helper used to form the expected parity bit of a byte
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 32'd25000000;

    // Encoding of the 2-bit stop_bits setting; the value 3 behaves as STOP_1.
    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_2   = 2'd1;
    localparam logic [1:0] STOP_1P5 = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        DONE   = 3'd6
    } uart_state_e;

    // Parity bit the line carries for a byte: even -> XOR of the bits,
    // odd -> XNOR of the bits.
    function automatic logic parity_bit(input logic [7:0] byte_v, input logic odd);
        logic p;
        p = ^byte_v;
        return odd ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous level input.
// Both flops reset to 1 so an idle-high line never shows a spurious low.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronised copy of d (2 cycles latency)
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: byte-wide UART receiver with runtime baud, parity and stop-bit
// settings. Each completed frame (errored or not) produces a one-cycle
// valid pulse with the received byte and its error flags.
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   rx          in  asynchronous serial line, idle high
//   baudrate    in  bits per second, latched at start detection
//   stop_bits   in  0:1 stop, 1:2 stop, 2:1.5 stop, 3:1 stop
//   parity_en   in  parity bit present after the data bits
//   parity_type in  0 even, 1 odd
//   data        out last received byte
//   valid       out one-cycle pulse per completed frame
//   parity_err  out parity mismatch on the flagged frame
//   frame_err   out a checked stop bit was sampled low
//   busy        out high from start detection until back in IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [31:0] baudrate,
    input  logic [1:0]  stop_bits,
    input  logic        parity_en,
    input  logic        parity_type,
    output logic [7:0]  data,
    output logic        valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [31:0] CLK_FREQ_W = 32'(CLK_FREQ);

    uart_state_e state_r;
    uart_state_e state_next_s;

    logic        rx_s;
    logic        rx_prev_r;
    logic        start_edge_s;
    logic [31:0] period_s;
    logic        rate_ok_s;
    logic        baud_tick_s;

    logic [31:0] cnt_r;
    logic [31:0] baud_limit_r;
    logic [31:0] half_limit_r;
    logic [1:0]  stop_bits_r;
    logic        par_en_r;
    logic        par_type_r;
    logic [7:0]  shreg_r;
    logic [2:0]  bit_idx_r;
    logic        par_err_r;
    logic        frm_err_r;

    logic [7:0]  data_next_s;
    logic        valid_next_s;
    logic        parity_err_next_s;
    logic        frame_err_next_s;
    logic        busy_next_s;

    logic [7:0]  data_r;
    logic        valid_r;
    logic        parity_err_r;
    logic        frame_err_r;
    logic        busy_r;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Previous synchronised level, for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev_r <= 1'b1;
        end else begin
            rx_prev_r <= rx_s;
        end
    end

    // A held-low line gives only one edge, so it cannot retrigger.
    assign start_edge_s = rx_prev_r & ~rx_s;

    // Live bit period from the current baud setting; only used at start detection.
    assign period_s  = (baudrate == 32'd0) ? 32'd0 : (CLK_FREQ_W / baudrate);
    assign rate_ok_s = (period_s >= 32'd4);

    assign baud_tick_s = (cnt_r == baud_limit_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_edge_s && rate_ok_s) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                // A line back high at mid start bit is treated as a glitch.
                if (cnt_r == half_limit_r) begin
                    state_next_s = rx_s ? IDLE : DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (baud_tick_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = par_en_r ? PARITY : STOP1;
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (baud_tick_s) begin
                    state_next_s = STOP1;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP1: begin
                if (baud_tick_s) begin
                    // The extra half bit of 1.5-stop mode is not sampled.
                    case (stop_bits_r)
                        STOP_2:           state_next_s = STOP2;
                        STOP_1, STOP_1P5: state_next_s = DONE;
                        default:          state_next_s = DONE;
                    endcase
                end else begin
                    state_next_s = STOP1;
                end
            end
            STOP2: begin
                if (baud_tick_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = STOP2;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Bit timing counter, frame settings and shift/error datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r        <= 32'd0;
            baud_limit_r <= 32'd0;
            half_limit_r <= 32'd0;
            stop_bits_r  <= STOP_1;
            par_en_r     <= 1'b0;
            par_type_r   <= 1'b0;
            shreg_r      <= 8'd0;
            bit_idx_r    <= 3'd0;
            par_err_r    <= 1'b0;
            frm_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 32'd0;
                    if (start_edge_s && rate_ok_s) begin
                        baud_limit_r <= period_s - 32'd1;
                        half_limit_r <= (period_s >> 1) - 32'd1;
                        stop_bits_r  <= stop_bits;
                    end
                end
                START: begin
                    if (cnt_r == half_limit_r) begin
                        cnt_r      <= 32'd0;
                        bit_idx_r  <= 3'd0;
                        par_en_r   <= parity_en;
                        par_type_r <= parity_type;
                        par_err_r  <= 1'b0;
                        frm_err_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                DATA: begin
                    if (baud_tick_s) begin
                        cnt_r     <= 32'd0;
                        // LSB arrives first: shift in at the top, move right.
                        shreg_r   <= {rx_s, shreg_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                PARITY: begin
                    if (baud_tick_s) begin
                        cnt_r     <= 32'd0;
                        par_err_r <= (rx_s != parity_bit(shreg_r, par_type_r));
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                STOP1, STOP2: begin
                    if (baud_tick_s) begin
                        cnt_r <= 32'd0;
                        if (!rx_s) begin
                            frm_err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                DONE: begin
                    cnt_r <= 32'd0;
                end
                default: begin
                    cnt_r <= 32'd0;
                end
            endcase
        end
    end

    // Output decode: load frame results in DONE, otherwise hold.
    always_comb begin
        data_next_s       = data_r;
        valid_next_s      = 1'b0;
        parity_err_next_s = parity_err_r;
        frame_err_next_s  = frame_err_r;
        busy_next_s       = (state_next_s != IDLE);
        if (state_r == DONE) begin
            data_next_s       = shreg_r;
            valid_next_s      = 1'b1;
            parity_err_next_s = par_err_r & par_en_r;
            frame_err_next_s  = frm_err_r;
        end else begin
            valid_next_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r       <= 8'd0;
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            data_r       <= data_next_s;
            valid_r      <= valid_next_s;
            parity_err_r <= parity_err_next_s;
            frame_err_r  <= frame_err_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: table of serial frames driven onto rx, expected
// results pushed to a scoreboard queue and popped when valid pulses,
// plus hand-written glitch, mid-frame reset and invalid-baud sequences.
module tb_uart_rx;

    localparam int CLK_HZ = 25000000;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [31:0] baudrate;
    logic [1:0]  stop_bits;
    logic        parity_en;
    logic        parity_type;
    logic [7:0]  data;
    logic        valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    typedef struct {
        logic [7:0] dbyte;
        int         baud;
        logic [1:0] sb;
        logic       pen;
        logic       ptype;
        logic       pbit;
        logic       s1;
        logic       s2;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[13];

    int n_cmp;
    int n_fail;
    int cyc;
    int valid_cnt;
    int lat_fall;
    bit lat_armed;
    bit valid_prev;

    uart_rx #(.CLK_FREQ(CLK_HZ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .baudrate    (baudrate),
        .stop_bits   (stop_bits),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .data        (data),
        .valid       (valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Pops and compares one expected frame for every valid pulse.
    task automatic monitor();
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            if (valid) begin
                valid_cnt = valid_cnt + 1;
                check("valid_width", {31'd0, valid_prev}, 32'd0);
                if (lat_armed) begin
                    lat_armed = 1'b0;
                    d = cyc - lat_fall;
                    n_cmp = n_cmp + 1;
                    if (d < 2063 || d > 2065) begin
                        n_fail = n_fail + 1;
                        $display("FAIL latency: got %0d cycles, required 2063..2065", d);
                    end
                end
                if (sb_q.size() == 0) begin
                    n_cmp = n_cmp + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_valid: got data 0x%0h, required no valid", data);
                end else begin
                    e = sb_q.pop_front();
                    check("data", {24'd0, data}, {24'd0, e.d});
                    check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                    check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                end
            end
            valid_prev = valid;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame (called at a negedge) and records its expected result.
    task automatic send_vec(input vec_t v);
        int   p;
        exp_t e;
        p = CLK_HZ / v.baud;
        baudrate    = 32'(v.baud);
        stop_bits   = v.sb;
        parity_en   = v.pen;
        parity_type = v.ptype;
        e.d = v.exp_data;
        e.perr = v.exp_perr;
        e.ferr = v.exp_ferr;
        sb_q.push_back(e);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(v.dbyte[i], p);
        if (v.pen) send_bit(v.pbit, p);
        send_bit(v.s1, p);
        if (v.sb == 2'd1) send_bit(v.s2, p);
        else if (v.sb == 2'd2) send_bit(1'b1, p / 2);
        if (v.gap > 0) send_bit(1'b1, v.gap * p);
    endtask

    initial begin
        int v0;
        int f;
        bit busy_seen;

        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        valid_cnt = 0;
        lat_armed = 1'b0;
        valid_prev = 1'b0;
        rx = 1'b1;
        rst_n = 1'b0;
        baudrate = 32'd115200;
        stop_bits = 2'd0;
        parity_en = 1'b0;
        parity_type = 1'b0;

        //            byte   baud    sb    pen   ptype pbit  s1    s2   gap  exp   perr  ferr
        vecs[0]  = '{8'hA5, 115200, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 115200, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'h03, 1'b0, 1'b0};
        vecs[2]  = '{8'h03, 115200, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 8'h03, 1'b1, 1'b0};
        vecs[3]  = '{8'h55, 115200, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h55, 1'b0, 1'b1};
        vecs[4]  = '{8'h03, 115200, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h03, 1'b0, 1'b0};
        vecs[5]  = '{8'h5A, 115200, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8'h5A, 1'b0, 1'b1};
        vecs[6]  = '{8'hC3, 115200, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'hC3, 1'b0, 1'b0};
        vecs[7]  = '{8'h7E, 115200, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'h7E, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 115200, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 8'hFF, 1'b1, 1'b1};
        vecs[9]  = '{8'h00, 115200, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'hFF, 115200, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'hFF, 1'b0, 1'b0};
        vecs[11] = '{8'h3C, 115200, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h3C, 1'b0, 1'b0};
        vecs[12] = '{8'h3C,   9600, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h3C, 1'b0, 1'b0};

        fork
            monitor();
        join_none

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table of frames; vec 0 also checks rx-fall to valid latency.
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                lat_fall = cyc;
                lat_armed = 1'b1;
            end
            send_vec(vecs[i]);
        end
        repeat (300) @(negedge clk);
        check("table_drained", 32'(sb_q.size()), 32'd0);

        // Short low glitch: start rejected at mid start bit.
        baudrate = 32'd115200;
        stop_bits = 2'd0;
        parity_en = 1'b0;
        v0 = valid_cnt;
        f = cyc;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (65) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        repeat (300) @(negedge clk);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Reset during DATA bit 4, then a clean 0x81 frame.
        v0 = valid_cnt;
        send_bit(1'b0, 217);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 217);
        send_bit(1'b0, 100);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data", {24'd0, data}, 32'd0);
        send_bit(1'b1, 434);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_vec('{8'h81, 115200, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 8'h81, 1'b0, 1'b0});
        repeat (100) @(negedge clk);
        check("midrst_one_valid", 32'(valid_cnt - v0), 32'd1);

        // Invalid baud settings: zero and a period below 4 cycles.
        busy_seen = 1'b0;
        baudrate = 32'd0;
        for (int k = 0; k < 480; k++) begin
            if (k == 240) baudrate = 32'd7000000;
            rx = ((k / 20) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        rx = 1'b1;
        check("badbaud_busy", {31'd0, busy_seen}, 32'd0);
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver for the 25 MHz fabric. It is the receive-side counterpart of the existing UART transmitter and uses the same runtime line settings: baud rate, parity enable/type and stop-bit mode. It synchronises the asynchronous `rx` line, detects and validates start bits, and samples each bit at mid-period. Each frame is delivered as one `valid` pulse with `data` and error flags.

## Interface
- `CLK_FREQ`, 25000000, clock frequency in Hz used for bit-period computation
- `clk`  in  1  system clock, 25 MHz; single clock domain
- `rst_n`  in  1  reset, synchronous, active-low
- `rx`  in  1  serial line, asynchronous, idle high
- `baudrate`  in  32  bits per second; latched at start-bit detection
- `stop_bits`  in  2  0: 1 stop; 1: 2 stop; 2: 1.5 stop; 3: treated as 0
- `parity_en`  in  1  1: parity bit present after data
- `parity_type`  in  1  0: even, 1: odd
- `data`  out  8  last received byte, LSB first on line
- `valid`  out  1  one-cycle pulse per completed frame, including errored frames
- `parity_err`  out  1  parity mismatch on the frame flagged by `valid`
- `frame_err`  out  1  a checked stop bit sampled low
- `busy`  out  1  high from start detection until return to IDLE

## Operation
- `rx` passes through a 2-FF synchroniser to give `rx_s`. A third register holds `rx_prev` for edge detection.
- Bit period: `bit_period = CLK_FREQ / baudrate` (integer divide). `baud_limit = bit_period - 1` and `half_limit = bit_period/2 - 1`. All three are latched in IDLE when a start is detected.
- If `baudrate == 0` or `bit_period < 4`, start detection is suppressed and the block stays in IDLE.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE: on `rx_prev==1 && rx_s==0`, go to START, clear the counter and set `busy`.
- START: at `counter==half_limit`, sample `rx_s`.
  - 0: go to DATA with counter cleared and bit index 0.
  - 1: glitch; return to IDLE with no `valid`.
- DATA: at each `counter==baud_limit`, shift `rx_s` in at the MSB and shift right. After bit index 7, go to PARITY if `parity_en`, else STOP1.
- PARITY: sample at `baud_limit`. Expected bit is `^byte` for even, `~^byte` for odd. Set `parity_err` if the sampled bit differs from the expected bit.
- STOP1: sample at `baud_limit`; a low sample sets `frame_err`.
  - `stop_bits==1`: go to STOP2.
  - Otherwise (1 or 1.5 stop bits): go to DONE. The 0.5 bit is not checked.
- STOP2: sample at `baud_limit`; a low sample sets `frame_err`; go to DONE.
- DONE: for one cycle, register `data`, `parity_err` and `frame_err`, pulse `valid`, clear `busy`, and go to IDLE.
- Outputs hold their value until the next DONE.
- `parity_err` is forced 0 when `parity_en` is 0 for that frame.
- `baudrate` and `stop_bits` changes take effect only at the next start detection. `parity_en` and `parity_type` are sampled at the START→DATA transition.
- An `rx` low held through IDLE does not retrigger; a new falling edge is required.

## Timing
- Reset values: `data=0`, `valid=0`, `parity_err=0`, `frame_err=0`, `busy=0`, state IDLE, synchroniser registers = 1.
- Synchroniser plus edge detection: 3 cycles from `rx` pin fall to the START entry.
- Each sample point is `half_limit+1 + n*(baud_limit+1)` cycles after START entry, placing it at mid-bit.
- `valid` asserts 1 cycle after the final stop-bit sample and is high for exactly 1 cycle.
- The minimum gap between `valid` pulses is one frame time. Back-to-back frames are accepted because the block is back in IDLE about half a bit before the nominal stop-bit end.
- `rst_n` low mid-frame: on the next edge, all state returns to reset values and no `valid` is issued for the partial frame.

## Structure
- Shared package `uart_pkg`:
  - state encoding, shared with the transmitter's IDLE/START/DATA/PARITY/STOP naming
  - stop-bit mode constants (`STOP_1=0`, `STOP_2=1`, `STOP_1P5=2`)
  - `CLK_FREQ` default
  - a parity function
- One sub-module, `uart_sync`: 2-FF synchroniser with reset value 1, reusable for other async inputs.

## Test plan
- 115200 baud (`bit_period=217`, `half=107`), 8N1, byte 0xA5 -> one `valid` with `data=0xA5` and both error flags 0. `valid` occurs 3+108+9×217 cycles (±1) after the `rx` fall.
- Even parity, 0x03 with parity bit 0 -> `parity_err=0`. Same frame with parity bit 1 -> `parity_err=1` and `valid` still pulses. Odd parity with 0x03 and parity bit 1 -> `parity_err=0`.
- 8N1 frame 0x55 with the stop bit driven low -> `frame_err=1`, `data=0x55`. With `stop_bits=1` and only the second stop bit low -> `frame_err=1`.
- `rx` low pulse of 50 cycles at 115200 -> no `valid`, `busy` falls after the START sample, block back in IDLE.
- Loopback from the transmitter at 9600 baud, 2 stop bits, odd parity, bytes 0x00, 0xFF, 0x3C sent back-to-back -> three `valid` pulses in order with matching data and no errors.
- `rst_n` low for 1 cycle during DATA bit 4, then a clean 0x81 frame -> no `valid` for the partial frame, exactly one `valid` with `data=0x81`. Also `baudrate=0` with `rx` toggling -> `busy` stays 0.
